mac_add: RTL and testbench
==========================

Name: mac_add

Overview:
- Pipelined dual-product multiply-add: m_data = a_data*b_data + c_data*d_data on unsigned DW-bit operands.
- Used as the arithmetic core of the MAC datapath. Consumes one operand set per clock and produces a registered result with a valid flag.
- Fixed two-cycle latency.

Parameters:
- DW, 8, operand and m_data width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand set on a/b/c/d_data is valid this cycle.
- a_data  input  DW  unsigned multiplicand A.
- b_data  input  DW  unsigned multiplier B.
- c_data  input  DW  unsigned multiplicand C.
- d_data  input  DW  unsigned multiplier D.
- m_data  output  DW  result: low DW bits of a*b + c*d.
- m_full  output  2*DW+1  full-precision result a*b + c*d.
- m_ovf  output  1  high when m_full does not fit in DW bits (m_full >= 2**DW).
- out_valid  output  1  m_data, m_full and m_ovf are valid this cycle.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n).
- While rst_n=0 at a rising edge, all pipeline registers clear. m_data=0, m_full=0, m_ovf=0 and out_valid=0 from that edge on.
- Stage 1 (edge N):
  - p_ab <= a_data*b_data and p_cd <= c_data*d_data, each 2*DW bits, unsigned, exact.
  - v1 <= in_valid.
- Stage 2 (edge N+1):
  - sum <= p_ab + p_cd, 2*DW+1 bits, exact with no loss.
  - v2 <= v1.
  - m_data <= sum[DW-1:0] (wrap-around truncation).
  - m_ovf <= |sum[2*DW:DW].
  - out_valid <= v1.
- Latency: operands sampled at edge N appear on the outputs after edge N+1 (2 cycles). Throughput is 1 result per clock.
- No backpressure: the pipeline always advances.
- Stage-1 product registers load only when in_valid=1.
- Stage-2 result registers (m_data, m_full, m_ovf) load only when v1=1. When out_valid=0 the outputs hold their last valid result.
- Inputs with in_valid=0 never produce out_valid=1.
- Reset mid-operation: in-flight results are discarded, and out_valid is 0 for the two cycles after reset release unless new valid input arrives.
- Corner cases:
  - Operands all zero -> 0, m_ovf=0.
  - Operands all ones -> m_full = 2*(2**DW-1)**2 with no truncation inside m_full.
- All outputs are driven directly from registers; there is no combinational input-to-output path.

Optional Feature:
- Macro MAC_ADD_SAT_EN.
- When defined: m_data saturates to all-ones (2**DW-1) whenever overflow occurs; m_ovf still reports the overflow and m_full is unchanged.
- When undefined: m_data is the wrap-around truncation sum[DW-1:0].

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs and in_valid=1 -> m_data=0, m_full=0, m_ovf=0, out_valid=0 throughout reset.
- Basic, back-to-back, DW=8:
  - (2,3,3,5) -> m_data=21, ovf=0.
  - (3,4,2,1) -> 14.
  - (5,3,1,2) -> 17.
  - (23,2,5,5) -> 71.
  - Each result appears exactly 2 cycles after its inputs, out_valid=1 on consecutive cycles.
- Overflow, wrap build:
  - (21,4,23,15) -> m_full=429, m_data=173, ovf=1.
  - (14,7,13,25) -> m_full=423, m_data=167, ovf=1.
  - (38,6,33,15) -> m_full=723, m_data=211, ovf=1.
- Overflow, MAC_ADD_SAT_EN build: the same three operand sets -> m_data=255, ovf=1, m_full unchanged (429, 423, 723).
- Valid gating: in_valid pattern 1,0,0,1 with the second set (7,3,2,1)=23 -> out_valid pattern 1,0,0,1 two cycles later; m_data holds its previous value while out_valid=0.
- Extremes: all operands 255 -> m_full=130050, m_data=2, ovf=1; all operands 0 -> 0, ovf=0.

Source files
------------

// File: rtl/mac_add.sv
// Two-stage pipelined dual-product multiply-add: {a*b + c*d} on unsigned DW-bit operands.
// Define MAC_ADD_SAT_EN to saturate m_data to all-ones on overflow instead of wrapping.
module mac_add #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [DW-1:0]   a_data,
    input  logic [DW-1:0]   b_data,
    input  logic [DW-1:0]   c_data,
    input  logic [DW-1:0]   d_data,
    output logic [DW-1:0]   m_data,
    output logic [2*DW:0]   m_full,
    output logic            m_ovf,
    output logic            out_valid
);

    logic [2*DW-1:0] p_ab_q, p_ab_d;
    logic [2*DW-1:0] p_cd_q, p_cd_d;
    logic            v1_q;
    logic [2*DW:0]   sum;
    logic            sum_ovf;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic [2*DW:0]   m_full_q, m_full_d;
    logic            m_ovf_q, m_ovf_d;
    logic            out_valid_q;

    // Stage 1: products are widened before multiplying so nothing is lost.
    always_comb begin
        p_ab_d = p_ab_q;
        p_cd_d = p_cd_q;
        if (in_valid) begin
            p_ab_d = (2*DW)'(a_data) * (2*DW)'(b_data);
            p_cd_d = (2*DW)'(c_data) * (2*DW)'(d_data);
        end
    end

    // Stage 2: one extra bit holds the carry of the final add.
    always_comb begin
        sum      = {1'b0, p_ab_q} + {1'b0, p_cd_q};
        sum_ovf  = |sum[2*DW:DW];
        m_full_d = m_full_q;
        m_ovf_d  = m_ovf_q;
        m_data_d = m_data_q;
        if (v1_q) begin
            m_full_d = sum;
            m_ovf_d  = sum_ovf;
`ifdef MAC_ADD_SAT_EN
            m_data_d = sum_ovf ? {DW{1'b1}} : sum[DW-1:0];
`else
            m_data_d = sum[DW-1:0];
`endif
        end
    end

    // NOTE: all state uses non-blocking assignments and a synchronous reset;
    // hold behaviour lives in the _d logic so every register has a single writer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_ab_q      <= '0;
            p_cd_q      <= '0;
            v1_q        <= 1'b0;
            m_data_q    <= '0;
            m_full_q    <= '0;
            m_ovf_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p_ab_q      <= p_ab_d;
            p_cd_q      <= p_cd_d;
            v1_q        <= in_valid;
            m_data_q    <= m_data_d;
            m_full_q    <= m_full_d;
            m_ovf_q     <= m_ovf_d;
            out_valid_q <= v1_q;
        end
    end

    assign m_data    = m_data_q;
    assign m_full    = m_full_q;
    assign m_ovf     = m_ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_add.sv
// Self-checking bench for mac_add: directed vectors plus random traffic against a
// cycle-level arithmetic model. Honours MAC_ADD_SAT_EN for the expected m_data.
module tb_mac_add;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] a_data = '0, b_data = '0, c_data = '0, d_data = '0;
    logic [DW-1:0] m_data;
    logic [2*DW:0] m_full;
    logic          m_ovf;
    logic          out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: the operand set accepted one edge ago and the expected outputs.
    logic    prev_rst = 1'b0;
    logic    prev_v   = 1'b0;
    longint  prev_full = 0;
    longint  exp_full = 0;
    longint  exp_data = 0;
    logic    exp_ovf = 1'b0;
    logic    exp_valid = 1'b0;

    mac_add #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a_data    (a_data),
        .b_data    (b_data),
        .c_data    (c_data),
        .d_data    (d_data),
        .m_data    (m_data),
        .m_full    (m_full),
        .m_ovf     (m_ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, advance the model and compare all outputs.
    task automatic step(input logic rst, input logic v,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
        longint lim;
        lim = longint'(1) << DW;
        rst_n = rst; in_valid = v;
        a_data = a; b_data = b; c_data = c; d_data = d;
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_full = 0; exp_data = 0; exp_ovf = 1'b0; exp_valid = 1'b0;
        end else if (prev_rst && prev_v) begin
            exp_full  = prev_full;
            exp_ovf   = (prev_full >= lim);
`ifdef MAC_ADD_SAT_EN
            exp_data  = exp_ovf ? lim - 1 : prev_full;
`else
            exp_data  = prev_full % lim;
`endif
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        prev_rst  = rst;
        prev_v    = v;
        prev_full = longint'(a) * longint'(b) + longint'(c) * longint'(d);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("m_data",    64'(m_data),    64'(exp_data));
        check("m_full",    64'(m_full),    64'(exp_full));
        check("m_ovf",     64'(m_ovf),     64'(exp_ovf));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    task automatic go(input int a, input int b, input int c, input int d);
        step(1'b1, 1'b1, DW'(a), DW'(b), DW'(c), DW'(d));
    endtask

    // Hand-computed values from the test plan, independent of the model.
    task automatic expect_lit(input string tag, input int data, input int full, input logic ovf);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".data"},  64'(m_data),    64'(data));
        check({tag, ".full"},  64'(m_full),    64'(full));
        check({tag, ".ovf"},   64'(m_ovf),     64'(ovf));
    endtask

    initial begin
        // Reset held with live traffic on the inputs.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));

        // Basic back-to-back vectors; each result is visible after the following edge.
        go(2, 3, 3, 5);
        go(3, 4, 2, 1);   expect_lit("basic0", 21, 21, 1'b0);
        go(5, 3, 1, 2);   expect_lit("basic1", 14, 14, 1'b0);
        go(23, 2, 5, 5);  expect_lit("basic2", 17, 17, 1'b0);
        idle();           expect_lit("basic3", 71, 71, 1'b0);
        idle();           check("basic.drain", 64'(out_valid), 64'(0));

        // Overflow vectors.
        go(21, 4, 23, 15);
        go(14, 7, 13, 25);
`ifdef MAC_ADD_SAT_EN
        expect_lit("ovf0", 255, 429, 1'b1);
        go(38, 6, 33, 15); expect_lit("ovf1", 255, 423, 1'b1);
        idle();            expect_lit("ovf2", 255, 723, 1'b1);
`else
        expect_lit("ovf0", 173, 429, 1'b1);
        go(38, 6, 33, 15); expect_lit("ovf1", 167, 423, 1'b1);
        idle();            expect_lit("ovf2", 211, 723, 1'b1);
`endif

        // Valid gating 1,0,0,1: outputs hold while out_valid is low.
        go(1, 1, 1, 1);
        idle();           expect_lit("gate0", 2, 2, 1'b0);
        idle();           check("gate.hold1", 64'(m_data), 64'(2));
        go(7, 3, 2, 1);   check("gate.hold2", 64'(m_data), 64'(2));
        idle();           expect_lit("gate3", 23, 23, 1'b0);

        // Extremes.
        go(255, 255, 255, 255);
        go(0, 0, 0, 0);
`ifdef MAC_ADD_SAT_EN
        expect_lit("ones", 255, 130050, 1'b1);
`else
        expect_lit("ones", 2, 130050, 1'b1);
`endif
        idle();           expect_lit("zeros", 0, 0, 1'b0);

        // Reset mid-flight: in-flight sets are discarded, no valid after release.
        go(9, 9, 9, 9);
        go(8, 8, 8, 8);
        step(1'b0, 1'b1, 8'd5, 8'd5, 8'd5, 8'd5);
        idle();           check("midrst.v0", 64'(out_valid), 64'(0));
        idle();           check("midrst.v1", 64'(out_valid), 64'(0));

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 19) != 0), 1'($urandom),
                 DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the clocked sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
